md_unit: RTL and testbench

Parametrised multiply/divide unit for the pipelined MIPS core. It sits in the E stage beside the ALU and takes the decoder's MDU function select plus operands rs/rt. It owns the HI/LO registers and runs multiply and divide operations over a configurable number of cycles, reporting `busy` to the stall logic. It also drops requests on an exception flush and gives divide-by-zero and signed-overflow a defined result.

---
 rtl/md_unit.sv | 122 ++++++++++++
 tb/tb_md_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit: owns HI/LO, runs mult/div over a fixed cycle count.
// Results land in staging registers and commit when the down-counter expires.
module md_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [2:0]       op,
    input  logic             kill,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mf_sel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   stage_hi;
    logic [WIDTH-1:0]   stage_lo;
    logic               commit;

    logic               accept;
    logic               is_mul;
    logic               is_div;
    logic               is_mthi;
    logic               is_mtlo;
    logic               sgn;

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign busy    = (cnt != '0);
    assign accept  = req & ~kill & ~busy;
    assign is_mul  = (op[2:1] == 2'b00);
    assign is_div  = (op[2:1] == 2'b01);
    assign is_mthi = (op == 3'b100);
    assign is_mtlo = (op == 3'b101);
    assign sgn     = ~op[0];

    // Low 2W bits of the extended product equal the true signed/unsigned product
    always_comb begin
        a_ext = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        b_ext = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        prod  = a_ext * b_ext;
    end

    // Signed divide via magnitudes; -2^(W-1)/-1 falls out as 2^(W-1), rem 0
    always_comb begin
        a_mag  = (sgn & a[WIDTH-1]) ? -a : a;
        b_mag  = (sgn & b[WIDTH-1]) ? -b : b;
        b_safe = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quo    = (sgn & (a[WIDTH-1] ^ b[WIDTH-1])) ? -q_mag : q_mag;
        rem    = (sgn & a[WIDTH-1]) ? -r_mag : r_mag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            stage_hi <= '0;
            stage_lo <= '0;
            commit   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            if (busy) begin
                cnt <= cnt - CW'(1);
            end
            if ((cnt == CW'(1)) && commit) begin
                hi <= stage_hi;
                lo <= stage_lo;
            end
            if (accept) begin
                unique case (1'b1)
                    is_mul: begin
                        stage_hi <= prod[2*WIDTH-1:WIDTH];
                        stage_lo <= prod[WIDTH-1:0];
                        commit   <= 1'b1;
                        cnt      <= CW'(MUL_CYCLES);
                    end
                    is_div: begin
                        stage_hi <= rem;
                        stage_lo <= quo;
                        commit   <= (b != '0);
                        cnt      <= CW'(DIV_CYCLES);
                    end
                    is_mthi: hi <= a;
                    is_mtlo: lo <= a;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        mf_data = '0;
        case (mf_sel)
            2'b00:   mf_data = hi;
            2'b01:   mf_data = lo;
            default: mf_data = '0;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed scenarios plus randomized back-to-back ops
// checked against an arithmetic reference model of HI/LO.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        kill = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  mf_sel = 2'b00;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    md_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .kill(kill),
        .a(a), .b(b), .mf_sel(mf_sel), .busy(busy),
        .hi(hi), .lo(lo), .mf_data(mf_data)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic; returns expected busy cycles
    function automatic int model(input logic [2:0] o, input logic [31:0] x,
                                 input logic [31:0] y);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy;
        logic [63:0]     p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        case (o)
            3'd0: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; return 5; end
            3'd1: begin p = ux * uy; m_hi = p[63:32]; m_lo = p[31:0]; return 5; end
            3'd2: begin
                if (y != 0) begin
                    sq = sx / sy; sr = sx % sy;
                    m_lo = sq[31:0]; m_hi = sr[31:0];
                end
                return 10;
            end
            3'd3: begin
                if (y != 0) begin
                    p = ux / uy; m_lo = p[31:0];
                    p = ux % uy; m_hi = p[31:0];
                end
                return 10;
            end
            3'd4: begin m_hi = x; return 0; end
            3'd5: begin m_lo = x; return 0; end
            default: return 0;
        endcase
    endfunction

    // Called at a negedge; leaves req low at the negedge after the edge
    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        req = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic count_busy(output int n, output bit held);
        logic [31:0] oh, ol;
        oh = hi; ol = lo; n = 0; held = 1'b1;
        while (busy && n < 100) begin
            if (hi !== oh || lo !== ol || mf_data !== oh) held = 1'b0;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", lo); end
        n_cmp++; if (mf_data !== 32'h0) begin n_bad++; $display("FAIL reset_mf got %h want 0", mf_data); end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith(input string nm, input logic [2:0] o,
                              input logic [31:0] x, input logic [31:0] y);
        int n, want_n;
        bit held;
        want_n = model(o, x, y);
        issue(o, x, y);
        count_busy(n, held);
        n_cmp++; if (n != want_n) begin n_bad++; $display("FAIL %s_busy_cycles got %0d want %0d", nm, n, want_n); end
        n_cmp++; if (!held) begin n_bad++; $display("FAIL %s_hold got changed want stable", nm); end
        n_cmp++; if (hi !== m_hi) begin n_bad++; $display("FAIL %s_hi got %h want %h", nm, hi, m_hi); end
        n_cmp++; if (lo !== m_lo) begin n_bad++; $display("FAIL %s_lo got %h want %h", nm, lo, m_lo); end
    endtask

    task automatic test_multu;
        test_arith("multu", 3'd1, 32'hFFFF_FFFF, 32'd2);
        n_cmp++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_const got %h_%h want 00000001_fffffffe", hi, lo); end
    endtask

    task automatic test_mult;
        test_arith("mult", 3'd0, -32'sd3, 32'd5);
        n_cmp++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL mult_const got %h_%h want ffffffff_fffffff1", hi, lo); end
    endtask

    task automatic test_div;
        test_arith("div", 3'd2, -32'sd7, 32'd2);
        n_cmp++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_const got hi %h lo %h want ffffffff fffffffd", hi, lo); end
        test_arith("divu", 3'd3, 32'd7, 32'd2);
        n_cmp++; if (lo !== 32'd3 || hi !== 32'd1) begin n_bad++; $display("FAIL divu_const got hi %h lo %h want 1 3", hi, lo); end
        test_arith("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        n_cmp++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin n_bad++; $display("FAIL div_ovf_const got hi %h lo %h want 0 80000000", hi, lo); end
    endtask

    task automatic test_div_zero;
        void'(model(3'd4, 32'h11, 32'h0));
        issue(3'd4, 32'h11, 32'h0);
        n_cmp++; if (busy !== 1'b0 || hi !== 32'h11) begin n_bad++; $display("FAIL mthi got busy %0b hi %h want 0 11", busy, hi); end
        void'(model(3'd5, 32'h22, 32'h0));
        issue(3'd5, 32'h22, 32'h0);
        n_cmp++; if (busy !== 1'b0 || lo !== 32'h22) begin n_bad++; $display("FAIL mtlo got busy %0b lo %h want 0 22", busy, lo); end
        test_arith("divz", 3'd2, 32'd1234, 32'd0);
    endtask

    task automatic test_kill;
        logic [31:0] oh;
        oh = hi;
        kill = 1'b1;
        issue(3'd4, 32'h55, 32'h0);
        kill = 1'b0;
        n_cmp++; if (hi !== oh) begin n_bad++; $display("FAIL kill_mthi got %h want %h", hi, oh); end
        kill = 1'b1;
        issue(3'd2, 32'd9, 32'd3);
        kill = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL kill_div_busy got %0b want 0", busy); end
    endtask

    task automatic test_ignored_busy;
        int n;
        bit held;
        void'(model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        kill = 1'b1;
        issue(3'd0, 32'h7, 32'h7);
        kill = 1'b0;
        issue(3'd0, 32'hDEAD_BEEF, 32'h3);
        count_busy(n, held);
        n_cmp++; if (n != 3) begin n_bad++; $display("FAIL ign_busy_cycles got %0d want 3", n); end
        n_cmp++; if (hi !== m_hi || lo !== m_lo) begin n_bad++; $display("FAIL ign_result got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_noop;
        logic [31:0] oh, ol;
        oh = hi; ol = lo;
        issue(3'd6, 32'hAAAA_AAAA, 32'h5);
        issue(3'd7, 32'hBBBB_BBBB, 32'h5);
        n_cmp++; if (busy !== 1'b0 || hi !== oh || lo !== ol) begin n_bad++; $display("FAIL noop got busy %0b %h_%h want 0 %h_%h", busy, hi, lo, oh, ol); end
    endtask

    task automatic test_random_back_to_back;
        logic [2:0]  o;
        logic [31:0] x, y, want;
        int n, want_n;
        bit held;
        for (int k = 0; k < 40; k++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            if (k % 5 == 0) y = 32'h0;
            if (k % 7 == 3) begin o = 3'd2; x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if (k % 4 == 1) y = {28'h0, y[3:0]};
            want_n = model(o, x, y);
            issue(o, x, y);
            if (want_n == 0) begin
                n = 0; held = 1'b1;
            end else begin
                count_busy(n, held);
            end
            n_cmp++; if (n != want_n) begin n_bad++; $display("FAIL rnd%0d_cycles op %0d got %0d want %0d", k, o, n, want_n); end
            n_cmp++; if (!held || hi !== m_hi || lo !== m_lo) begin n_bad++; $display("FAIL rnd%0d_result op %0d a %h b %h got %h_%h want %h_%h", k, o, x, y, hi, lo, m_hi, m_lo); end
            mf_sel = 2'($urandom_range(0, 3));
            want = (mf_sel == 2'b00) ? m_hi : (mf_sel == 2'b01) ? m_lo : 32'h0;
            #1;
            n_cmp++; if (mf_data !== want) begin n_bad++; $display("FAIL rnd%0d_mf sel %0d got %h want %h", k, mf_sel, mf_data, want); end
            mf_sel = 2'b00;
        end
    endtask

    task automatic test_reset_mid;
        int n;
        bit held;
        issue(3'd4, 32'hAA, 32'h0);
        issue(3'd3, 32'd100, 32'd7);
        @(negedge clk); @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin n_bad++; $display("FAIL rst_mid got busy %0b %h_%h want 0 0_0", busy, hi, lo); end
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (12) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin n_bad++; $display("FAIL rst_nocommit got busy %0b %h_%h want 0 0_0", busy, hi, lo); end
        void'(model(3'd5, 32'h9, 32'h0));
        issue(3'd5, 32'h9, 32'h0);
        count_busy(n, held);
        n_cmp++; if (n != 0 || lo !== 32'h9) begin n_bad++; $display("FAIL rst_mtlo got busy %0d lo %h want 0 9", n, lo); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_kill();
        test_ignored_busy();
        test_noop();
        test_random_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
